sram_capture_ctrl: RTL and testbench
====================================

Name: sram_capture_ctrl

Overview:
- Initiator for the 1024x32 dual-port SRAM macro: drives port 0 (RW, byte-masked) for writes and port 1 (R) for reads.
- Captures 8-bit SAR ADC samples into SRAM as a byte stream, one sample per byte lane.
- Exposes the SRAM window and control/status registers to the Caravel Wishbone bus, so firmware can configure capture and read samples back.
- Both SRAM clocks (clk0, clk1) are tied to wb_clk_i at the top level.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base. SRAM window is BASE+0x0000..0x0FFF; registers are at BASE+0x1000..0x100C.
- DEPTH_LOG2, 10, SRAM word address width. Byte pointer width is DEPTH_LOG2+2.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte select.
- wbs_adr_i  in  32  Wishbone byte address.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_ack_o  out  1  Wishbone acknowledge, one-cycle pulse.
- wbs_dat_o  out  32  Wishbone read data.
- sample_i  in  8  ADC sample.
- sample_valid_i  in  1  one-cycle sample strobe.
- irq_o  out  1  level; high while STATUS.done=1.
- sram_csb0  out  1  port 0 chip select, active low.
- sram_web0  out  1  port 0 write enable, active low.
- sram_wmask0  out  4  port 0 byte write mask.
- sram_addr0  out  10  port 0 word address.
- sram_din0  out  32  port 0 write data.
- sram_csb1  out  1  port 1 chip select, active low.
- sram_addr1  out  10  port 1 word address.
- sram_dout1  in  32  port 1 read data.

Behaviour:
- Reset values:
  - Outputs: ack=0, dat_o=0, irq_o=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, csb1=1, addr1=0.
  - Internal: CTRL=0, byte pointer=0, COUNT=0, STATUS=0, pending sample cleared.
- All SRAM port outputs are registered. The SRAM captures them on the next rising edge, and read data is valid at the rising edge after that.
- Registers:
  - CTRL (0x1000, RW): bit0 en; bit1 cont (1=wrap, 0=one-shot); bit2 clr (write-1 pulse, reads 0). clr zeroes the pointer, COUNT, done and ovf.
  - STATUS (0x1004, RO): bit0 busy (en & !done), bit1 done, bit2 ovf (sticky). A write of 1 to bit2 clears ovf.
  - WPTR (0x1008, RO): 12-bit byte pointer.
  - COUNT (0x100C, RO): 13 bits, saturates at 4096.
  - Unmapped addresses: ack after 1 cycle, read 0, write ignored.
- Wishbone FSM states: IDLE, REG_ACK, RD1, RD2, WR_WAIT, ACK.
  - IDLE: a request is accepted when cyc&stb=1 and ack=0.
  - Register access goes to REG_ACK. Ack is asserted the cycle after the request is accepted.
  - SRAM read: drive csb1=0 and addr1=adr[11:2], then RD1, then RD2. wbs_dat_o is latched from sram_dout1 on entry to ACK. Ack is 3 cycles after acceptance, with csb1 returned to 1 after one cycle.
  - SRAM write: goes to WR_WAIT. When port 0 is free, drive csb0=0, web0=0, wmask0=sel, din0=dat_i, then ACK. Port 0 is held for exactly one cycle.
  - Ack is deasserted the cycle after it is asserted, and the FSM returns to IDLE.
- Capture path:
  - A sample_valid_i is latched into a 1-entry pending register only while busy; otherwise it is ignored.
  - Pending samples have port 0 priority over Wishbone writes. A Wishbone write waits at most one cycle.
  - Issue: addr0=ptr[11:2], wmask0=1<<ptr[1:0], din0={4{sample}}. Then ptr increments and COUNT increments (saturating).
  - A sample_valid_i arriving while pending is still set and not issuing that cycle: sample dropped, ovf=1.
  - Pointer reaching 4095 and issuing:
    - cont=1: ptr wraps to 0.
    - cont=0: ptr wraps to 0, done=1, and the capture stops. Later samples are ignored with no ovf.
  - Writing en=1 with done=1 does not restart capture. clr is required first.
- Simultaneous events:
  - clr and a sample in the same cycle: clr wins and the sample is dropped.
  - A CTRL write of en=0 with a sample pending: the pending sample is still issued.
- Reset mid-operation: the FSM returns to IDLE with no ack, the pending sample is dropped, and SRAM strobes return to inactive on the next cycle.

Test Plan:
- Reset, then read STATUS -> 0x0, ack 1 cycle after accept. irq_o=0 and csb0=csb1=1 throughout reset.
- WB write 0xDEADBEEF, sel=4'b0110, to BASE+0x010 over prior 0 -> readback 0x00ADBE00, with ack 3 cycles after accept.
- CTRL=0x1 (one-shot), 4 samples 0x11,0x22,0x33,0x44 -> word 0 reads 0x44332211, WPTR=4, COUNT=4.
- One-shot, 4096 samples -> done=1, irq_o=1, WPTR=0. Sample 4097 ignored: COUNT=4096, ovf=0.
- Sample strobe and WB write to port 0 in the same cycle -> sample written first and WB ack one cycle later. Both bytes are correct in memory.
- cont=1, 4100 samples -> word 0 holds samples 4097..4100, COUNT=4096. Two back-to-back strobes while blocked -> ovf=1; write STATUS bit2 -> ovf=0.

Source files
------------

// File: rtl/sram_capture_ctrl.sv
// Wishbone-attached capture controller: streams 8-bit ADC samples into a 1024x32 dual-port SRAM
// (port 0 writes, port 1 reads) and exposes the memory window plus CTRL/STATUS/WPTR/COUNT.
module sram_capture_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [7:0]            sample_i,
  input  logic                  sample_valid_i,
  output logic                  irq_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [DEPTH_LOG2-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  output logic                  sram_csb1,
  output logic [DEPTH_LOG2-1:0] sram_addr1,
  input  logic [31:0]           sram_dout1
);

  localparam int unsigned PtrW = DEPTH_LOG2 + 2;
  localparam int unsigned CntW = DEPTH_LOG2 + 3;
  localparam logic [CntW-1:0] CntMax = {1'b1, {PtrW{1'b0}}};
  localparam logic [31:0] RegBase = BASE_ADDR + 32'h0000_1000;

  typedef enum logic [2:0] {StIdle, StRegAck, StRd1, StRd2, StWrWait, StAck} state_e;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d, waited_q, waited_d;
  logic [31:0]           dat_q, dat_d, din0_q, din0_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
  logic [3:0]            wmask0_q, wmask0_d;
  logic [DEPTH_LOG2-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic                  en_q, en_d, cont_q, cont_d, done_q, done_d, ovf_q, ovf_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  pend_q, pend_d;
  logic [7:0]            pend_data_q, pend_data_d;

  logic        accept, sram_hit, reg_hit, reg_wr, clr_now, busy, wr_go, issue, last, take;
  logic [31:0] reg_rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign accept   = wbs_cyc_i & wbs_stb_i & ~ack_q & (state_q == StIdle);
  assign sram_hit = wbs_adr_i[31:PtrW] == BASE_ADDR[31:PtrW];
  assign reg_hit  = wbs_adr_i[31:4] == RegBase[31:4];
  assign reg_wr   = accept & wbs_we_i & reg_hit;
  assign clr_now  = reg_wr & (wbs_adr_i[3:2] == 2'd0) & wbs_dat_i[2];
  assign busy     = en_q & ~done_q;
  // A Wishbone write yields port 0 to a pending sample once, then takes it unconditionally.
  assign wr_go    = (state_q == StWrWait) & (~pend_q | waited_q);
  assign issue    = pend_q & ~wr_go & ~clr_now;
  assign last     = issue & ~cont_q & (ptr_q == '1);
  // A strobe coinciding with the final one-shot write must not leak into a finished buffer.
  assign take     = sample_valid_i & busy & ~clr_now & ~last;

  always_comb begin
    reg_rdata = '0;
    if (reg_hit) begin
      case (wbs_adr_i[3:2])
        2'd0:    reg_rdata = {30'd0, cont_q, en_q};
        2'd1:    reg_rdata = {29'd0, ovf_q, done_q, busy};
        2'd2:    reg_rdata = 32'(ptr_q);
        default: reg_rdata = 32'(count_q);
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = dat_q;
    waited_d    = waited_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    wmask0_d    = wmask0_q;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    csb1_d      = 1'b1;
    addr1_d     = addr1_q;
    en_d        = en_q;
    cont_d      = cont_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (sram_hit && wbs_we_i) begin
            state_d  = StWrWait;
            waited_d = 1'b0;
          end else if (sram_hit) begin
            csb1_d  = 1'b0;
            addr1_d = wbs_adr_i[PtrW-1:2];
            state_d = StRd1;
          end else begin
            state_d = StRegAck;
            ack_d   = 1'b1;
            dat_d   = wbs_we_i ? '0 : reg_rdata;
          end
        end
      end
      StRegAck: state_d = StIdle;
      StRd1:    state_d = StRd2;
      StRd2: begin
        dat_d   = sram_dout1;
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StWrWait: begin
        if (wr_go) state_d = StAck;
        else       waited_d = 1'b1;
      end
      // Write acks are raised once the SRAM has captured the write strobe.
      StAck: begin
        if (ack_q) state_d = StIdle;
        else       ack_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (reg_wr && wbs_adr_i[3:2] == 2'd0) begin
      en_d   = wbs_dat_i[0];
      cont_d = wbs_dat_i[1];
      if (wbs_dat_i[2]) begin
        ptr_d   = '0;
        count_d = '0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        pend_d  = 1'b0;
      end
    end else if (reg_wr && wbs_adr_i[3:2] == 2'd1 && wbs_dat_i[2]) begin
      ovf_d = 1'b0;
    end

    if (wr_go) begin
      csb0_d   = 1'b0;
      web0_d   = 1'b0;
      wmask0_d = wbs_sel_i;
      addr0_d  = wbs_adr_i[PtrW-1:2];
      din0_d   = wbs_dat_i;
    end else if (issue) begin
      csb0_d   = 1'b0;
      web0_d   = 1'b0;
      wmask0_d = 4'b0001 << ptr_q[1:0];
      addr0_d  = ptr_q[PtrW-1:2];
      din0_d   = {4{pend_data_q}};
      ptr_d    = ptr_q + PtrW'(1);
      pend_d   = 1'b0;
      if (count_q != CntMax) count_d = count_q + CntW'(1);
      if (last) done_d = 1'b1;
    end

    if (take) begin
      if (pend_q && !issue) begin
        ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = sample_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      waited_q    <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      wmask0_q    <= '0;
      addr0_q     <= '0;
      din0_q      <= '0;
      csb1_q      <= 1'b1;
      addr1_q     <= '0;
      en_q        <= 1'b0;
      cont_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      waited_q    <= waited_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      wmask0_q    <= wmask0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      csb1_q      <= csb1_d;
      addr1_q     <= addr1_d;
      en_q        <= en_d;
      cont_q      <= cont_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign irq_o       = done_q;
  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;

endmodule

// File: tb/tb_sram_capture_ctrl.sv
// Directed bench for sram_capture_ctrl with a behavioural dual-port SRAM model.
module tb_sram_capture_ctrl;

  localparam logic [31:0] Base   = 32'h3000_0000;
  localparam logic [31:0] RCtrl  = 32'h3000_1000;
  localparam logic [31:0] RStat  = 32'h3000_1004;
  localparam logic [31:0] RWptr  = 32'h3000_1008;
  localparam logic [31:0] RCount = 32'h3000_100C;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  sample_i;
  logic        sample_valid_i;
  logic        irq_o;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [9:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout1;

  always #5 wb_clk_i = ~wb_clk_i;

  sram_capture_ctrl dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .irq_o          (irq_o),
    .sram_csb0      (sram_csb0),
    .sram_web0      (sram_web0),
    .sram_wmask0    (sram_wmask0),
    .sram_addr0     (sram_addr0),
    .sram_din0      (sram_din0),
    .sram_csb1      (sram_csb1),
    .sram_addr1     (sram_addr1),
    .sram_dout1     (sram_dout1)
  );

  // SRAM model: inputs captured on the rising edge, read data valid by the following edge.
  logic [31:0] mem [1024];
  logic        mem_clr;

  always @(posedge wb_clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      sram_dout1 <= '0;
    end else begin
      if (!sram_csb0 && !sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; optional sample strobes in the first nsamp cycles of the request.
  // lat is the cycle (request cycle = 0) in which ack is seen high; 99 if it never arrives.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int nsamp, input logic [7:0] sbase,
                         output logic [31:0] rdata, output int lat);
    logic got;
    got   = 1'b0;
    lat   = 99;
    rdata = '0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int c = 0; c < 20 && !got; c++) begin
      sample_valid_i = (c < nsamp);
      sample_i       = sbase + 8'(c);
      tick();
      if (wbs_ack_o) begin
        got   = 1'b1;
        lat   = c + 1;
        rdata = wbs_dat_o;
      end
    end
    sample_valid_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    tick();
  endtask

  task automatic wb_rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 0, 8'h00, rd, lat);
    check(name, rd, exp);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b1, adr, dat, 4'hF, 0, 8'h00, rd, lat);
  endtask

  task automatic send_sample(input logic [7:0] v);
    sample_valid_i = 1'b1;
    sample_i       = v;
    tick();
    sample_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;

    vecs[0]  = '{1'b0, RStat,             32'h0,         4'hF, 1'b1, 32'h0,         1};
    vecs[1]  = '{1'b1, Base + 32'h010,    32'hDEADBEEF,  4'h6, 1'b0, 32'h0,         3};
    vecs[2]  = '{1'b0, Base + 32'h010,    32'h0,         4'hF, 1'b1, 32'h00ADBE00,  3};
    vecs[3]  = '{1'b1, Base + 32'hFFC,    32'h12345678,  4'hF, 1'b0, 32'h0,         3};
    vecs[4]  = '{1'b0, Base + 32'hFFC,    32'h0,         4'hF, 1'b1, 32'h12345678,  3};
    vecs[5]  = '{1'b0, Base + 32'h2000,   32'h0,         4'hF, 1'b1, 32'h0,         1};
    vecs[6]  = '{1'b1, Base + 32'h1010,   32'hFFFFFFFF,  4'hF, 1'b0, 32'h0,         1};
    vecs[7]  = '{1'b0, RCtrl,             32'h0,         4'hF, 1'b1, 32'h0,         1};
    vecs[8]  = '{1'b1, RCtrl,             32'h7,         4'hF, 1'b0, 32'h0,         1};
    vecs[9]  = '{1'b0, RCtrl,             32'h0,         4'hF, 1'b1, 32'h3,         1};
    vecs[10] = '{1'b0, RStat,             32'h0,         4'hF, 1'b1, 32'h1,         1};
    vecs[11] = '{1'b1, RCtrl,             32'h4,         4'hF, 1'b0, 32'h0,         1};
    vecs[12] = '{1'b0, RStat,             32'h0,         4'hF, 1'b1, 32'h0,         1};
    vecs[13] = '{1'b0, RWptr,             32'h0,         4'hF, 1'b1, 32'h0,         1};

    wb_rst_i = 1'b1;
    mem_clr  = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    sample_i  = '0;
    sample_valid_i = 1'b0;
    tick();
    mem_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_irq", irq_o, 1'b0);
      check("rst_csb0", sram_csb0, 1'b1);
      check("rst_csb1", sram_csb1, 1'b1);
      tick();
    end
    wb_rst_i = 1'b0;
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_port0", {sram_web0, sram_wmask0, sram_addr0, sram_din0[15:0]}, {1'b1, 30'h0});
    check("rst_addr1", sram_addr1, 10'h0);

    for (int i = 0; i < 14; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 0, 8'h00, rd, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end

    // One-shot, four samples packed into word 0.
    wb_wr(RCtrl, 32'h1);
    send_sample(8'h11);
    send_sample(8'h22);
    send_sample(8'h33);
    send_sample(8'h44);
    wb_rd("four_word0", Base, 32'h44332211);
    wb_rd("four_wptr", RWptr, 32'd4);
    wb_rd("four_count", RCount, 32'd4);
    wb_rd("four_status", RStat, 32'h1);

    // One-shot full buffer: wraps, sets done, ignores further samples.
    wb_wr(RCtrl, 32'h5);
    for (int k = 0; k < 4096; k++) send_sample(8'(k));
    tick();
    check("full_irq", irq_o, 1'b1);
    wb_rd("full_status", RStat, 32'h2);
    wb_rd("full_wptr", RWptr, 32'd0);
    wb_rd("full_count", RCount, 32'd4096);
    send_sample(8'hEE);
    wb_rd("extra_count", RCount, 32'd4096);
    wb_rd("extra_status", RStat, 32'h2);
    wb_rd("extra_word0", Base, 32'h03020100);
    wb_wr(RCtrl, 32'h1);
    wb_rd("norestart_status", RStat, 32'h2);

    // Sample and Wishbone write contend for port 0 in the same cycle.
    wb_wr(RCtrl, 32'h5);
    wb_xfer(1'b1, Base, 32'h00005A00, 4'h2, 1, 8'hA5, rd, lat);
    check("contend_lat", lat, 32'd4);
    wb_rd("contend_word0", Base, 32'h03025AA5);
    wb_rd("contend_wptr", RWptr, 32'd1);

    // Continuous mode past the end of the buffer.
    wb_wr(RCtrl, 32'h7);
    for (int k = 1; k <= 4100; k++)
      send_sample((k <= 4096) ? 8'(k) : 8'(k - 4096 + 'hC0));
    wb_rd("cont_word0", Base, 32'hC4C3C2C1);
    wb_rd("cont_count", RCount, 32'd4096);
    wb_rd("cont_wptr", RWptr, 32'd4);
    wb_rd("cont_status", RStat, 32'h1);

    // Strobes every cycle while a Wishbone write holds port 0: third sample overflows.
    wb_xfer(1'b1, Base + 32'h100, 32'hCAFEF00D, 4'hF, 3, 8'hD0, rd, lat);
    check("ovf_lat", lat, 32'd4);
    wb_rd("ovf_status", RStat, 32'h5);
    wb_rd("ovf_wptr", RWptr, 32'd6);
    wb_rd("ovf_word1", Base + 32'h004, 32'h0807D1D0);
    wb_rd("ovf_wbword", Base + 32'h100, 32'hCAFEF00D);
    wb_wr(RStat, 32'h4);
    wb_rd("ovfclr_status", RStat, 32'h1);

    // Reset in the middle of an SRAM read.
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = Base;
    tick();
    check("midrst_csb1_on", sram_csb1, 1'b0);
    wb_rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_csb1", sram_csb1, 1'b1);
      check("midrst_ack", wbs_ack_o, 1'b0);
    end
    wb_rst_i  = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    tick();
    wb_rd("midrst_status", RStat, 32'h0);
    wb_rd("midrst_count", RCount, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
